ahb_lite_cmd_master: RTL and testbench

Synthesizable AHB-Lite initiator that converts single-transfer commands (valid/ready) into pipelined NONSEQ/SINGLE bus transfers and returns in-order responses through a buffered response port. It is the master-side counterpart to the team's AHB slave models. It drives those models in block-level benches and serves as a simple register-access master in subsystems.

---
 rtl/ahb_pkg.sv | 44 ++++
 rtl/ahb_master_rsp_fifo.sv | 65 ++++++
 rtl/ahb_lite_cmd_master.sv | 169 ++++++++++++++++
 tb/tb_ahb_lite_cmd_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and small helpers for the command master.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Response payload carried through the response FIFO (33 bits).
    typedef struct packed {
        logic        error;
        logic [31:0] rdata;
    } rsp_t;

    // Bus error state: ERR_ACTIVE covers the second cycle of a two-cycle ERROR.
    typedef enum logic {
        ERR_CLEAR  = 1'b0,
        ERR_ACTIVE = 1'b1
    } err_state_t;

    // A command is rejected locally when its size is wider than a word or the
    // address is not aligned to the transfer size.
    function automatic logic size_reject(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = addr_lo[0];
            HSIZE_WORD: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_master_rsp_fifo.sv
// Synchronous response FIFO; the head entry is read straight from the
// registered storage so the response port carries no combinational path.
module ahb_master_rsp_fifo
    import ahb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop = pop & ~empty;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                assert (!full);
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage write; contents need no reset because empty gates the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: single-transfer commands in, NONSEQ/SINGLE transfers on
// the bus, in-order responses out through a small response FIFO.
//
// Handshakes (command and response ports): a beat transfers on a rising edge
// where VALID and READY are both high; VALID, once raised, is held with stable
// payload until it transfers; READY never depends combinationally on VALID.
module ahb_lite_cmd_master
    import ahb_pkg::*;
#(
    parameter int AWIDTH    = 10,
    parameter int RSP_DEPTH = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [AWIDTH-1:0] CMD_ADDR,
    input  logic [2:0]        CMD_SIZE,
    input  logic [31:0]       CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERROR,
    output logic [AWIDTH-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    // Address-phase register A
    logic              a_valid;
    logic              a_write;
    logic              a_reject;
    logic [AWIDTH-1:0] a_addr;
    logic [2:0]        a_size;
    logic [31:0]       a_wdata;

    // Data-phase register D
    logic              d_valid;
    logic              d_write;
    logic              d_reject;
    logic [31:0]       d_wdata;

    err_state_t        err_q;
    err_state_t        err_d;

    logic              cmd_accept;
    logic              cmd_reject;
    logic              complete;
    logic              credit_ok;
    logic [31:0]       outstanding;
    rsp_t              push_rsp;
    rsp_t              head_rsp;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Every accepted command owns a FIFO slot until its response is popped,
    // so the FIFO can never be pushed while full.
    assign outstanding = 32'(fifo_count) + 32'(a_valid) + 32'(d_valid);
    assign credit_ok   = (outstanding < 32'(RSP_DEPTH));
    assign CMD_READY   = ~HRESET & (err_q == ERR_CLEAR) & (~a_valid | HREADY) & credit_ok;
    assign cmd_accept  = CMD_VALID & CMD_READY;
    assign cmd_reject  = size_reject(CMD_SIZE, CMD_ADDR[1:0]);

    assign complete       = d_valid & HREADY;
    assign push_rsp.error = (HRESP == HRESP_ERROR) | d_reject;
    assign push_rsp.rdata = (d_write | push_rsp.error) ? 32'h0 : HRDATA;

    // Rejected entries and the cancelled cycle of an ERROR show IDLE on the bus.
    assign HTRANS    = (a_valid && !a_reject && err_q == ERR_CLEAR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = a_addr;
    assign HWRITE    = a_write;
    assign HSIZE     = a_size;
    assign HWDATA    = d_wdata;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;

    assign RSP_VALID = ~fifo_empty;
    assign RSP_RDATA = head_rsp.rdata;
    assign RSP_ERROR = head_rsp.error;

    // Error state register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_q <= ERR_CLEAR;
        end else begin
            err_q <= err_d;
        end
    end

    // Error next-state: first ERROR cycle arms it, the completing cycle clears it
    always_comb begin
        err_d = err_q;
        case (err_q)
            ERR_CLEAR:  if (d_valid && !HREADY && HRESP == HRESP_ERROR) err_d = ERR_ACTIVE;
            ERR_ACTIVE: if (HREADY) err_d = ERR_CLEAR;
            default:    err_d = ERR_CLEAR;
        endcase
    end

    // Address/data pipeline; A is kept across an ERROR so it reissues unchanged
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid  <= 1'b0;
            a_write  <= 1'b0;
            a_reject <= 1'b0;
            a_addr   <= '0;
            a_size   <= '0;
            a_wdata  <= '0;
            d_valid  <= 1'b0;
            d_write  <= 1'b0;
            d_reject <= 1'b0;
            d_wdata  <= '0;
        end else if (HREADY) begin
            if (err_q == ERR_ACTIVE) begin
                d_valid <= 1'b0;
            end else begin
                d_valid  <= a_valid;
                d_write  <= a_write;
                d_reject <= a_reject;
                d_wdata  <= a_wdata;
                a_valid  <= cmd_accept;
                if (cmd_accept) begin
                    a_write  <= CMD_WRITE;
                    a_reject <= cmd_reject;
                    a_addr   <= CMD_ADDR;
                    a_size   <= CMD_SIZE;
                    a_wdata  <= CMD_WDATA;
                end
            end
        end else if (cmd_accept) begin
            // Only reachable with A empty: fill it while the data phase waits.
            a_valid  <= 1'b1;
            a_write  <= CMD_WRITE;
            a_reject <= cmd_reject;
            a_addr   <= CMD_ADDR;
            a_size   <= CMD_SIZE;
            a_wdata  <= CMD_WDATA;
        end
    end

    ahb_master_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_t))
    ) u_rsp_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (complete),
        .push_data (push_rsp),
        .pop       (RSP_READY),
        .head      (head_rsp),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: directed commands, a reactive memory slave,
// and a command-level model that predicts bus transfers and responses.
module tb_ahb_lite_cmd_master;
    import ahb_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic          CMD_WRITE = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [2:0]    CMD_SIZE = '0;
    logic [31:0]   CMD_WDATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERROR;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic          HMASTLOCK;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA = '0;
    logic          HREADY = 1'b1;
    logic          HRESP = 1'b0;

    ahb_lite_cmd_master #(.AWIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERROR(RSP_ERROR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [2:0]    size;
        logic [31:0]   wdata;
    } xfer_t;

    xfer_t         xfer_q[$];
    logic [32:0]   exp_q[$];
    logic [32:0]   rsp_log[$];
    logic [31:0]   model_mem [256];
    logic [31:0]   slave_mem [256];
    logic [AW-1:0] err_addr = 10'h020;
    int            wait_cfg = 0;
    int            acc_cnt  = 0;
    int            xfer_cnt = 0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Command-level model: each accepted command either becomes one bus
    // transfer or an immediate local error, and yields exactly one response.
    task automatic model_accept(input logic w, input logic [AW-1:0] a,
                                input logic [2:0] s, input logic [31:0] d);
        int  sz;
        logic bad;
        xfer_t x;
        sz  = int'(s);
        bad = (sz > 2) || ((int'(a) % (1 << sz)) != 0);
        if (bad) begin
            exp_q.push_back({1'b1, 32'h0});
        end else begin
            x.addr = a; x.write = w; x.size = s; x.wdata = d;
            xfer_q.push_back(x);
            if (a == err_addr) exp_q.push_back({1'b1, 32'h0});
            else if (w) begin
                model_mem[a[AW-1:2]] = d;
                exp_q.push_back({1'b0, 32'h0});
            end else exp_q.push_back({1'b0, model_mem[a[AW-1:2]]});
        end
    endtask

    // ---------------- slave + compare process ----------------
    logic          s_rst, s_cvalid, s_cready, s_cwrite, s_hready, s_write, s_rvalid, s_rready, s_rerr;
    logic [AW-1:0] s_caddr, s_addr;
    logic [2:0]    s_csize, s_size;
    logic [1:0]    s_trans;
    logic [31:0]   s_cwdata, s_hwdata, s_rdata;
    logic          sl_dp_valid = 1'b0;
    logic          sl_dp_write = 1'b0;
    logic [AW-1:0] sl_dp_addr  = '0;
    int            sl_waits = 0;
    int            sl_err_stage = 0;
    logic          dpc_valid = 1'b0;
    logic          dpc_write = 1'b0;
    logic [31:0]   dpc_wdata = '0;

    initial begin
        xfer_t x;
        logic [32:0] e;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = init_word(i);
            model_mem[i] = init_word(i);
        end
        forever begin
            // Mid-cycle snapshot: what the next rising edge will act on.
            @(negedge HCLK);
            s_rst = HRESET; s_cvalid = CMD_VALID; s_cready = CMD_READY; s_cwrite = CMD_WRITE;
            s_caddr = CMD_ADDR; s_csize = CMD_SIZE; s_cwdata = CMD_WDATA;
            s_trans = HTRANS; s_addr = HADDR; s_write = HWRITE; s_size = HSIZE;
            s_hwdata = HWDATA; s_hready = HREADY;
            s_rvalid = RSP_VALID; s_rready = RSP_READY; s_rerr = RSP_ERROR; s_rdata = RSP_RDATA;
            if (s_rst) begin
                xfer_q.delete();
                exp_q.delete();
                dpc_valid = 1'b0;
            end else begin
                check("bus_const", 64'({HBURST, HPROT, HMASTLOCK, (s_trans == HTRANS_IDLE || s_trans == HTRANS_NONSEQ)}),
                      64'({3'b000, 4'b0011, 1'b0, 1'b1}));
                if (s_cvalid && s_cready) begin
                    model_accept(s_cwrite, s_caddr, s_csize, s_cwdata);
                    acc_cnt++;
                end
                if (s_hready) begin
                    if (dpc_valid && dpc_write) check("hwdata", 64'(s_hwdata), 64'(dpc_wdata));
                    dpc_valid = 1'b0;
                    if (s_trans == HTRANS_NONSEQ) begin
                        xfer_cnt++;
                        check("xfer_expected", 64'(xfer_q.size() != 0), 64'(1));
                        if (xfer_q.size() != 0) begin
                            x = xfer_q.pop_front();
                            check("xfer", 64'({s_addr, s_write, s_size}), 64'({x.addr, x.write, x.size}));
                            dpc_valid = 1'b1;
                            dpc_write = x.write;
                            dpc_wdata = x.wdata;
                        end
                    end
                end
                if (s_rvalid && s_rready) begin
                    rsp_log.push_back({s_rerr, s_rdata});
                    check("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rsp", 64'({s_rerr, s_rdata}), 64'(e));
                    end
                end
            end
            @(posedge HCLK);
            #1;
            if (s_rst) begin
                sl_dp_valid = 1'b0;
            end else if (s_hready) begin
                if (sl_dp_valid && sl_dp_write && sl_err_stage == 0)
                    slave_mem[sl_dp_addr[AW-1:2]] = s_hwdata;
                sl_dp_valid  = (s_trans == HTRANS_NONSEQ);
                sl_dp_addr   = s_addr;
                sl_dp_write  = s_write;
                sl_waits     = wait_cfg;
                sl_err_stage = (s_addr == err_addr) ? 2 : 0;
            end else begin
                if (sl_waits > 0) sl_waits--;
                else if (sl_err_stage == 2) sl_err_stage = 1;
            end
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
            if (sl_dp_valid) begin
                if (sl_waits > 0) HREADY = 1'b0;
                else if (sl_err_stage == 2) begin HREADY = 1'b0; HRESP = 1'b1; end
                else if (sl_err_stage == 1) HRESP = 1'b1;
                else if (!sl_dp_write) HRDATA = slave_mem[sl_dp_addr[AW-1:2]];
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [2:0] s, input logic [31:0] d);
        int t;
        t = 0;
        CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_SIZE = s; CMD_WDATA = d;
        do begin
            @(negedge HCLK);
            t++;
        end while (!CMD_READY && t < 200);
        check("cmd_accepted", 64'(CMD_READY), 64'(1));
        @(posedge HCLK);
        #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(negedge HCLK);
            t++;
        end while (exp_q.size() != 0 && t < 200);
        check("drain", 64'(exp_q.size()), 64'(0));
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int x0;
        int a0;
        int cnt;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_bus", 64'({HTRANS, HADDR, HWRITE, HSIZE, HWDATA}), 64'(0));
        check("rst_rsp_valid", 64'(RSP_VALID), 64'(0));
        check("rst_cmd_ready", 64'(CMD_READY), 64'(0));
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // 1: zero-wait write then read back
        base = rsp_log.size();
        send(1'b1, 10'h010, 3'd2, 32'hDEADBEEF);
        @(negedge HCLK);
        check("t1_addr_phase", 64'({HTRANS, HADDR, HWRITE}), 64'({HTRANS_NONSEQ, 10'h010, 1'b1}));
        @(negedge HCLK);
        check("t1_data_phase", 64'(HWDATA), 64'(32'hDEADBEEF));
        check("t1_rsp_not_yet", 64'(RSP_VALID), 64'(0));
        @(negedge HCLK);
        check("t1_rsp_latency", 64'({RSP_VALID, RSP_ERROR}), 64'({1'b1, 1'b0}));
        @(posedge HCLK);
        #1;
        send(1'b0, 10'h010, 3'd2, 32'h0);
        drain();
        check("t1_readback", 64'(rsp_log[base + 1]), 64'({1'b0, 32'hDEADBEEF}));

        // 2: back-to-back reads with two wait states each
        base = rsp_log.size();
        x0 = xfer_cnt;
        wait_cfg = 2;
        send(1'b0, 10'h000, 3'd2, 32'h0);
        send(1'b0, 10'h004, 3'd2, 32'h0);
        cnt = 0;
        repeat (6) begin
            @(negedge HCLK);
            if (HTRANS == HTRANS_NONSEQ && HADDR == 10'h004 && !HREADY) cnt++;
        end
        @(posedge HCLK);
        #1;
        drain();
        wait_cfg = 0;
        check("t2_held_cycles", 64'(cnt), 64'(2));
        check("t2_xfers", 64'(xfer_cnt - x0), 64'(2));
        check("t2_rsp0", 64'(rsp_log[base]), 64'({1'b0, 32'hC0DE0000}));
        check("t2_rsp1", 64'(rsp_log[base + 1]), 64'({1'b0, 32'hC0DE0001}));

        // 3: two-cycle ERROR on a write while a read waits in the address phase
        base = rsp_log.size();
        send(1'b1, 10'h020, 3'd2, 32'hCAFEF00D);
        send(1'b0, 10'h024, 3'd2, 32'h0);
        @(negedge HCLK);
        check("t3_err_cycle1", 64'({HTRANS, HREADY, HRESP}), 64'({HTRANS_NONSEQ, 1'b0, 1'b1}));
        @(negedge HCLK);
        check("t3_err_cycle2", 64'({HTRANS, HREADY, HRESP}), 64'({HTRANS_IDLE, 1'b1, 1'b1}));
        @(negedge HCLK);
        check("t3_reissue", 64'({HTRANS, HADDR, HREADY}), 64'({HTRANS_NONSEQ, 10'h024, 1'b1}));
        @(posedge HCLK);
        #1;
        drain();
        check("t3_rsp0", 64'(rsp_log[base]), 64'({1'b1, 32'h0}));
        check("t3_rsp1", 64'(rsp_log[base + 1]), 64'({1'b0, 32'hC0DE0009}));

        // 4: misaligned word read rejected locally, byte read proceeds
        base = rsp_log.size();
        x0 = xfer_cnt;
        send(1'b0, 10'h002, 3'd2, 32'h0);
        send(1'b0, 10'h003, 3'd0, 32'h0);
        drain();
        check("t4_xfers", 64'(xfer_cnt - x0), 64'(1));
        check("t4_rsp0", 64'(rsp_log[base]), 64'({1'b1, 32'h0}));
        check("t4_rsp1", 64'(rsp_log[base + 1]), 64'({1'b0, 32'hC0DE0000}));

        // 5: response back-pressure limits outstanding commands
        base = rsp_log.size();
        a0 = acc_cnt;
        RSP_READY = 1'b0;
        send(1'b1, 10'h040, 3'd2, 32'h11111111);
        send(1'b1, 10'h044, 3'd2, 32'h22222222);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 10'h040; CMD_SIZE = 3'd2; CMD_WDATA = 32'h0;
        cnt = 0;
        repeat (8) begin
            @(negedge HCLK);
            if (CMD_READY) cnt++;
        end
        check("t5_ready_low", 64'(cnt), 64'(0));
        check("t5_accepted", 64'(acc_cnt - a0), 64'(2));
        check("t5_rsp_waiting", 64'(RSP_VALID), 64'(1));
        @(posedge HCLK);
        #1;
        RSP_READY = 1'b1;
        send(1'b0, 10'h040, 3'd2, 32'h0);
        send(1'b0, 10'h044, 3'd2, 32'h0);
        drain();
        check("t5_rsp0", 64'(rsp_log[base]), 64'({1'b0, 32'h0}));
        check("t5_rsp1", 64'(rsp_log[base + 1]), 64'({1'b0, 32'h0}));
        check("t5_rsp2", 64'(rsp_log[base + 2]), 64'({1'b0, 32'h11111111}));
        check("t5_rsp3", 64'(rsp_log[base + 3]), 64'({1'b0, 32'h22222222}));

        // 6: reset during a waited data phase
        wait_cfg = 5;
        send(1'b0, 10'h008, 3'd2, 32'h0);
        @(negedge HCLK);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("t6_waiting", 64'(HREADY), 64'(0));
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(negedge HCLK);
        check("t6_ready_in_reset", 64'(CMD_READY), 64'(0));
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        wait_cfg = 0;
        @(negedge HCLK);
        check("t6_after_reset", 64'({HTRANS, RSP_VALID}), 64'({HTRANS_IDLE, 1'b0}));
        @(posedge HCLK);
        #1;
        base = rsp_log.size();
        send(1'b1, 10'h030, 3'd2, 32'h12345678);
        send(1'b0, 10'h030, 3'd2, 32'h0);
        drain();
        check("t6_rsp_count", 64'(rsp_log.size() - base), 64'(2));
        check("t6_readback", 64'(rsp_log[base + 1]), 64'({1'b0, 32'h12345678}));

        repeat (3) @(negedge HCLK);
        check("end_xfers_done", 64'(xfer_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
